// File: rtl/cube_pkg.sv
// Shared cube constants, face ordering and colour type used by the facelet
// sequencer and the downstream cube-map stage.
package cube_pkg;
  localparam int NUM_FACES = 6;
  localparam int STICKERS  = 9;
  localparam int FACELETS  = NUM_FACES * STICKERS;
  localparam int COLOR_W   = 30;

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t RESET_COLOR = 30'h3FFF_FFFF;

  typedef enum logic [2:0] {
    FACE_U = 3'd0,
    FACE_D = 3'd1,
    FACE_B = 3'd2,
    FACE_F = 3'd3,
    FACE_L = 3'd4,
    FACE_R = 3'd5
  } face_t;

  // First entry of each face; avoids a face*9 multiplier.
  localparam logic [NUM_FACES-1:0][6:0] FACE_BASE = {7'd45, 7'd36, 7'd27, 7'd18, 7'd9, 7'd0};

  function automatic logic face_legal(input logic [2:0] code);
    return (code <= 3'd5);
  endfunction

  function automatic logic [6:0] entry_addr(input face_t face, input logic [3:0] sticker);
    return FACE_BASE[face] + {3'b000, sticker};
  endfunction
endpackage

// File: rtl/facelet_sequencer_if.sv
// Sticker capture stream between the colour-sampling stage (master) and the
// facelet sequencer (slave).
interface facelet_sequencer_if;
  import cube_pkg::*;

  logic        cap_start;
  logic [2:0]  cap_face;
  logic        cap_valid;
  color_t      cap_color;
  logic        cap_ready;
  logic        face_done;
  logic        cap_err;

  modport master (
    output cap_start, cap_face, cap_valid, cap_color,
    input  cap_ready, face_done, cap_err
  );

  modport slave (
    input  cap_start, cap_face, cap_valid, cap_color,
    output cap_ready, face_done, cap_err
  );
endinterface

// File: rtl/facelet_store.sv
// 54-entry colour register file: one synchronous write port, one
// combinational read port, all entries cleared to RESET_COLOR on reset.
module facelet_store
  import cube_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       we,
  input  logic [6:0] waddr,
  input  color_t     wdata,
  input  logic [6:0] raddr,
  output color_t     rdata
);
  color_t mem_r [FACELETS];

  // Entry storage with whole-array clear on reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < FACELETS; i++) begin
        mem_r[i] <= RESET_COLOR;
      end
    end else if (we && (waddr < 7'(FACELETS))) begin
      mem_r[waddr[5:0]] <= wdata;
    end
  end

  // Out-of-range reads return the reset colour rather than X.
  always_comb begin
    if (raddr < 7'(FACELETS)) begin
      rdata = mem_r[raddr[5:0]];
    end else begin
      rdata = RESET_COLOR;
    end
  end
endmodule

// File: rtl/facelet_sequencer.sv
// Captures faces of sticker colours into the facelet store and continuously
// scans index/colour pairs out to the cube-map stage.
module facelet_sequencer
  import cube_pkg::*;
(
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic                  scan_en,
  facelet_sequencer_if.slave    cap,
  output logic [NUM_FACES-1:0]  faces_valid,
  output logic [6:0]            index,
  output color_t                color_out,
  output logic                  busy
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t                state_r;
  face_t                 face_r;
  logic [3:0]            count_r;
  logic [6:0]            index_r;
  color_t                color_r;
  logic [NUM_FACES-1:0]  faces_valid_r;
  logic                  cap_ready_r;
  logic                  face_done_r;
  logic                  cap_err_r;
  logic                  busy_r;

  logic                  we_s;
  logic [6:0]            waddr_s;
  logic [6:0]            next_index_s;
  color_t                rdata_s;
  logic                  start_legal_s;

  // Scan pointer wrap, write strobe and capture legality.
  always_comb begin
    next_index_s  = 7'd0;
    we_s          = 1'b0;
    waddr_s       = entry_addr(face_r, count_r);
    start_legal_s = cap.cap_start && face_legal(cap.cap_face);
    if (index_r == 7'(FACELETS - 1)) begin
      next_index_s = 7'd0;
    end else begin
      next_index_s = index_r + 7'd1;
    end
    if ((state_r == ST_CAPTURE) && cap.cap_valid && cap_ready_r) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  facelet_store u_store (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .we        (we_s),
    .waddr     (waddr_s),
    .wdata     (cap.cap_color),
    .raddr     (next_index_s),
    .rdata     (rdata_s)
  );

  // Control FSM with all outputs registered.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_r       <= ST_IDLE;
      face_r        <= FACE_U;
      count_r       <= 4'd0;
      index_r       <= 7'd0;
      color_r       <= RESET_COLOR;
      faces_valid_r <= {NUM_FACES{1'b0}};
      cap_ready_r   <= 1'b0;
      face_done_r   <= 1'b0;
      cap_err_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      face_done_r <= 1'b0;
      cap_err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_legal_s) begin
            state_r     <= ST_CAPTURE;
            face_r      <= face_t'(cap.cap_face);
            count_r     <= 4'd0;
            cap_ready_r <= 1'b1;
            busy_r      <= 1'b1;
          end else if (cap.cap_start) begin
            cap_err_r <= 1'b1;
          end else if (scan_en) begin
            state_r <= ST_SCAN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (start_legal_s) begin
            // Index pauses here and resumes from the same value after capture.
            state_r     <= ST_CAPTURE;
            face_r      <= face_t'(cap.cap_face);
            count_r     <= 4'd0;
            cap_ready_r <= 1'b1;
            busy_r      <= 1'b1;
          end else if (cap.cap_start) begin
            cap_err_r <= 1'b1;
            index_r   <= next_index_s;
            color_r   <= rdata_s;
          end else if (scan_en) begin
            index_r <= next_index_s;
            color_r <= rdata_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          if (cap.cap_valid && cap_ready_r) begin
            if (count_r == 4'(STICKERS - 1)) begin
              count_r               <= 4'd0;
              face_done_r           <= 1'b1;
              faces_valid_r[face_r] <= 1'b1;
              cap_ready_r           <= 1'b0;
              busy_r                <= 1'b0;
              state_r               <= scan_en ? ST_SCAN : ST_IDLE;
            end else begin
              count_r <= count_r + 4'd1;
            end
          end else begin
            count_r <= count_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cap_ready_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign cap.cap_ready = cap_ready_r;
  assign cap.face_done = face_done_r;
  assign cap.cap_err   = cap_err_r;
  assign faces_valid   = faces_valid_r;
  assign index         = index_r;
  assign color_out     = color_r;
  assign busy          = busy_r;
endmodule

// File: tb/tb_facelet_sequencer.sv
// Directed-vector bench for facelet_sequencer: scan wrap, capture, stall,
// illegal face, reset mid-capture and capture on scan rise.
module tb_facelet_sequencer;
  import cube_pkg::*;

  logic        frame_clk;
  logic        Reset;
  logic        scan_en;
  logic [5:0]  faces_valid;
  logic [6:0]  index;
  color_t      color_out;
  logic        busy;
  int          total;
  int          bad;

  facelet_sequencer_if capif ();

  facelet_sequencer dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .scan_en     (scan_en),
    .cap         (capif),
    .faces_valid (faces_valid),
    .index       (index),
    .color_out   (color_out),
    .busy        (busy)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    scan_en = 1'b0;
    capif.cap_start = 1'b0;
    capif.cap_face = 3'd0;
    capif.cap_valid = 1'b0;
    capif.cap_color = 30'h0;
    step();
    Reset = 1'b0;
  endtask

  task automatic wait_index(input logic [6:0] tgt, input string tag);
    int n;
    n = 0;
    while ((index !== tgt) && (n < 120)) begin
      step();
      n++;
    end
    total++;
    if (index !== tgt) begin
      bad++;
      $display("FAIL %s: timeout, index=%0d want %0d", tag, index, tgt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total += 5;
    if (index !== 7'd0) begin bad++; $display("FAIL rst_index: got %0d want 0", index); end
    if (color_out !== 30'h3FFFFFFF) begin bad++; $display("FAIL rst_color: got %h want 3fffffff", color_out); end
    if (faces_valid !== 6'b0) begin bad++; $display("FAIL rst_fv: got %b want 0", faces_valid); end
    if ({capif.cap_ready, busy} !== 2'b00) begin bad++; $display("FAIL rst_ready_busy: got %b want 00", {capif.cap_ready, busy}); end
    if ({capif.face_done, capif.cap_err} !== 2'b00) begin bad++; $display("FAIL rst_pulses: got %b want 00", {capif.face_done, capif.cap_err}); end
  endtask

  task automatic test_scan_wrap();
    scan_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      total += 2;
      if (index !== 7'(k % 54)) begin bad++; $display("FAIL scan_index[%0d]: got %0d want %0d", k, index, k % 54); end
      if (color_out !== 30'h3FFFFFFF) begin bad++; $display("FAIL scan_color[%0d]: got %h want 3fffffff", k, color_out); end
    end
    total++;
    if (faces_valid !== 6'b0) begin bad++; $display("FAIL scan_fv: got %b want 0", faces_valid); end
  endtask

  task automatic test_capture_f();
    capif.cap_start = 1'b1;
    capif.cap_face = 3'd3;
    step();
    capif.cap_start = 1'b0;
    total++;
    if ({busy, capif.cap_ready, index} !== {2'b11, 7'd5}) begin
      bad++; $display("FAIL capf_enter: busy/ready/index got %b/%b/%0d want 1/1/5", busy, capif.cap_ready, index);
    end
    for (int b = 0; b < 9; b++) begin
      capif.cap_valid = 1'b1;
      capif.cap_color = 30'(b + 1);
      step();
      if (b < 8) begin
        total++;
        if ({capif.face_done, capif.cap_ready} !== 2'b01) begin
          bad++; $display("FAIL capf_beat[%0d]: done/ready got %b want 01", b, {capif.face_done, capif.cap_ready});
        end
      end
    end
    capif.cap_valid = 1'b0;
    total += 3;
    if (capif.face_done !== 1'b1) begin bad++; $display("FAIL capf_done: got %b want 1", capif.face_done); end
    if (faces_valid !== 6'b001000) begin bad++; $display("FAIL capf_fv: got %b want 001000", faces_valid); end
    if ({capif.cap_ready, busy, index} !== {2'b00, 7'd5}) begin
      bad++; $display("FAIL capf_exit: ready/busy/index got %b/%b/%0d want 0/0/5", capif.cap_ready, busy, index);
    end
    step();
    total++;
    if ({capif.face_done, index} !== {1'b0, 7'd6}) begin
      bad++; $display("FAIL capf_resume: done/index got %b/%0d want 0/6", capif.face_done, index);
    end
    wait_index(7'd27, "capf_wait27");
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      total++;
      if ({index, color_out} !== {7'(27 + k), 30'(k + 1)}) begin
        bad++; $display("FAIL capf_entry[%0d]: index/color got %0d/%h want %0d/%h", 27 + k, index, color_out, 27 + k, k + 1);
      end
    end
  endtask

  task automatic test_stall_pause();
    wait_index(7'd20, "stall_wait20");
    capif.cap_start = 1'b1;
    capif.cap_face = 3'd5;
    step();
    capif.cap_start = 1'b0;
    for (int c = 0; c < 17; c++) begin
      capif.cap_valid = (c % 2 == 0);
      capif.cap_color = (c % 2 == 0) ? 30'(32'h100 + c / 2) : 30'h2AAAAAAA;
      step();
      if (c < 16) begin
        total++;
        if ({capif.cap_ready, capif.face_done, index} !== {2'b10, 7'd20}) begin
          bad++; $display("FAIL stall_hold[%0d]: ready/done/index got %b/%b/%0d want 1/0/20", c, capif.cap_ready, capif.face_done, index);
        end
      end
    end
    total += 2;
    if (capif.face_done !== 1'b1) begin bad++; $display("FAIL stall_done: got %b want 1", capif.face_done); end
    if (faces_valid !== 6'b101000) begin bad++; $display("FAIL stall_fv: got %b want 101000", faces_valid); end
    // Beat offered while not ready must be dropped.
    capif.cap_valid = 1'b1;
    capif.cap_color = 30'h3ABCDEF;
    step();
    capif.cap_valid = 1'b0;
    total++;
    if (index !== 7'd21) begin bad++; $display("FAIL stall_resume: index got %0d want 21", index); end
    wait_index(7'd45, "stall_wait45");
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      total++;
      if ({index, color_out} !== {7'(45 + k), 30'(32'h100 + k)}) begin
        bad++; $display("FAIL stall_entry[%0d]: index/color got %0d/%h want %0d/%h", 45 + k, index, color_out, 45 + k, 32'h100 + k);
      end
    end
  endtask

  task automatic test_illegal_face();
    scan_en = 1'b0;
    step();
    total++;
    if (index !== 7'd53) begin bad++; $display("FAIL ill_idle: index got %0d want 53", index); end
    capif.cap_start = 1'b1;
    capif.cap_face = 3'd7;
    step();
    capif.cap_start = 1'b0;
    total += 2;
    if (capif.cap_err !== 1'b1) begin bad++; $display("FAIL ill_err: got %b want 1", capif.cap_err); end
    if ({capif.cap_ready, busy, index} !== {2'b00, 7'd53}) begin
      bad++; $display("FAIL ill_state: ready/busy/index got %b/%b/%0d want 0/0/53", capif.cap_ready, busy, index);
    end
    step();
    total++;
    if ({capif.cap_err, capif.cap_ready, faces_valid, index} !== {2'b00, 6'b101000, 7'd53}) begin
      bad++; $display("FAIL ill_after: err/ready/fv/index got %b/%b/%b/%0d want 0/0/101000/53",
                      capif.cap_err, capif.cap_ready, faces_valid, index);
    end
  endtask

  task automatic test_reset_mid_capture();
    capif.cap_start = 1'b1;
    capif.cap_face = 3'd0;
    step();
    capif.cap_start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      capif.cap_valid = 1'b1;
      capif.cap_color = 30'(32'h55 + b);
      step();
    end
    Reset = 1'b1;
    #1;
    total++;
    if ({busy, capif.cap_ready, faces_valid, index} !== {2'b00, 6'b0, 7'd0}) begin
      bad++; $display("FAIL rmid_async: busy/ready/fv/index got %b/%b/%b/%0d want 0/0/0/0", busy, capif.cap_ready, faces_valid, index);
    end
    capif.cap_valid = 1'b0;
    step();
    Reset = 1'b0;
    step();
    total++;
    if ({capif.face_done, busy} !== 2'b00) begin bad++; $display("FAIL rmid_nodone: done/busy got %b want 00", {capif.face_done, busy}); end
    scan_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({index, color_out} !== {7'(k), 30'h3FFFFFFF}) begin
        bad++; $display("FAIL rmid_entry[%0d]: index/color got %0d/%h want %0d/3fffffff", k, index, color_out, k);
      end
    end
  endtask

  task automatic test_capture_on_scan_rise();
    do_reset();
    scan_en = 1'b1;
    capif.cap_start = 1'b1;
    capif.cap_face = 3'd1;
    step();
    capif.cap_start = 1'b0;
    total++;
    if ({busy, capif.cap_ready, index} !== {2'b11, 7'd0}) begin
      bad++; $display("FAIL rise_enter: busy/ready/index got %b/%b/%0d want 1/1/0", busy, capif.cap_ready, index);
    end
    for (int b = 0; b < 9; b++) begin
      capif.cap_valid = 1'b1;
      capif.cap_color = 30'(32'h200 + b);
      step();
    end
    capif.cap_valid = 1'b0;
    total++;
    if ({capif.face_done, faces_valid, index} !== {1'b1, 6'b000010, 7'd0}) begin
      bad++; $display("FAIL rise_exit: done/fv/index got %b/%b/%0d want 1/000010/0", capif.face_done, faces_valid, index);
    end
    for (int k = 1; k < 18; k++) begin
      step();
      total++;
      if ({index, color_out} !== {7'(k), (k >= 9) ? 30'(32'h200 + k - 9) : 30'h3FFFFFFF}) begin
        bad++; $display("FAIL rise_entry[%0d]: index/color got %0d/%h", k, index, color_out);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_scan_wrap();
    test_capture_f();
    test_stall_pause();
    test_illegal_face();
    test_reset_mid_capture();
    test_capture_on_scan_rise();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
